// File: rtl/gps_sample_capture_pkg.sv
// gps_sample_capture_pkg: shared state encoding, word width and parameter legality helper
package gps_sample_capture_pkg;
    localparam int WORD_W = 16;
    typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} cap_state_t;
    function automatic bit sample_bits_ok(input int b);
        return b == 1 || b == 2 || b == 4 || b == 8;
    endfunction
endpackage

// File: rtl/gps_sample_capture_ram.sv
// sample_ram: simple dual-port DEPTH x 16 buffer, sync write, registered read with resettable output
module sample_ram
    import gps_sample_capture_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] q
);
    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (re) q <= mem[raddr];
endmodule

// File: rtl/gps_sample_capture.sv
// gps_sample_capture: decimates and packs N-bit IF samples into 16-bit words, buffers them
// in block RAM as one-shot fill or pre-trigger ring, and pops words out on read strobes.
module gps_sample_capture
    import gps_sample_capture_pkg::*;
#(
    parameter int SAMPLE_BITS = 2,
    parameter int DEPTH       = 1024,
    parameter int DECIM_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     mode,
    input  logic [DECIM_W-1:0]       decim,
    input  logic [SAMPLE_BITS-1:0]   din,
    input  logic                     rd,
    output logic [WORD_W-1:0]        dout,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underflow
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int SPW = WORD_W / SAMPLE_BITS;
    localparam int SW  = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int PW  = WORD_W - SAMPLE_BITS;

    if (!sample_bits_ok(SAMPLE_BITS) || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
        $error("gps_sample_capture: illegal SAMPLE_BITS or DEPTH");
    end

    cap_state_t         state, state_nxt;
    logic               mode_r, wrapped;
    logic [DECIM_W-1:0] decim_r, dcnt;
    logic [PW-1:0]      sreg;
    logic [SW-1:0]      scnt;
    logic [AW-1:0]      wr_ptr, rd_ptr, rd_addr;
    logic               accept, last, we, freeze, pop, uf, inc, wr_last;

    // A ring-mode read during capture is the trigger: it freezes and pops the oldest word at once.
    assign freeze  = !clr && rd && state == CAPTURE && mode_r;
    assign accept  = !clr && !freeze && state == CAPTURE && dcnt == '0;
    assign last    = scnt == SW'(SPW - 1);
    assign we      = accept && last;
    assign wr_last = wr_ptr == {AW{1'b1}};
    assign pop     = !clr && rd && count != '0;
    assign uf      = !clr && rd && count == '0;
    assign inc     = we && count != CW'(DEPTH);
    assign rd_addr = freeze ? (wrapped ? wr_ptr : '0) : rd_ptr;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        state_nxt = clr ? CAPTURE :
                    freeze ? HOLD :
                    (we && !mode_r && wr_last) ? HOLD : state;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            mode_r    <= 1'b0;
            decim_r   <= '0;
            dcnt      <= '0;
            sreg      <= '0;
            scnt      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            underflow <= 1'b0;
            wrapped   <= 1'b0;
        end else if (clr) begin
            mode_r    <= mode;
            decim_r   <= decim;
            dcnt      <= decim;
            sreg      <= '0;
            scnt      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            underflow <= 1'b0;
            wrapped   <= 1'b0;
        end else begin
            if (state == CAPTURE && !freeze) dcnt <= (dcnt == '0) ? decim_r : dcnt - 1'b1;
            if (accept) begin
                sreg <= PW'({sreg, din});
                scnt <= scnt + 1'b1;
            end
            if (we) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (mode_r && wr_last) wrapped <= 1'b1;
                if (!mode_r && wr_last) full <= 1'b1;
            end
            if (pop) rd_ptr <= rd_addr + 1'b1;
            if (uf) underflow <= 1'b1;
            count <= count + CW'(inc) - CW'(pop);
        end

    sample_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (wr_ptr),
        .wdata ({sreg, din}),
        .re    (pop),
        .raddr (rd_addr),
        .q     (dout)
    );
endmodule
